// File: rtl/status_pkg.sv
// Shared status-display constants and condition-selection helpers.
// Used by status_code_sel and by the downstream hex display block.
package status_pkg;

  localparam logic [11:0] STATUS_MEM_UNCALIB = 12'h500;
  localparam logic [11:0] STATUS_MEM_ERROR   = 12'h501;
  localparam logic [11:0] STATUS_DEFAULT     = 12'h100;

  localparam int IDX_UNCALIB = 0;
  localparam int IDX_MEMERR  = 1;
  localparam int IDX_FAULT   = 2;
  localparam int NUM_COND    = 3;

  typedef enum logic {ST_IDLE, ST_SHOW} sel_state_e;
  typedef logic [NUM_COND-1:0] cond_vec_t;
  typedef logic [1:0]          cond_idx_t;

  // Lowest set index; only meaningful when act != 0.
  function automatic cond_idx_t lowest_active(input cond_vec_t act);
    lowest_active = '0;
    for (int i = NUM_COND - 1; i >= 0; i--) begin
      if (act[i]) lowest_active = cond_idx_t'(i);
    end
  endfunction

  // Next set index above idx, wrapping; returns idx when it is the only one.
  function automatic cond_idx_t next_active(input cond_vec_t act, input cond_idx_t idx);
    int j;
    next_active = idx;
    for (int k = NUM_COND - 1; k >= 1; k--) begin
      j = (int'(idx) + k) % NUM_COND;
      if (act[j]) next_active = cond_idx_t'(j);
    end
  endfunction

endpackage

// File: rtl/status_code_sel_sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/status_code_sel.sv
// Resolves board status conditions to a 12-bit display code, rotating between active ones.
// Optional macro STATUS_STICKY_MEMERR_EN makes the memory-error condition sticky until fault_clear.
module status_code_sel
  import status_pkg::*;
#(
  parameter int ROTATE_CYCLES = 100000000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mcb3_calib_done,
  input  logic        mcb3_error,
  input  logic        fault_valid,
  input  logic [11:0] fault_code,
  input  logic        fault_clear,
  output logic [11:0] state_code,
  output logic        fault_pending,
  output logic        multi_active
);

  localparam int               CNT_W    = $clog2(ROTATE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROTATE_CYCLES - 1);

  logic w_cal_s, w_err_s, w_memerr;
  cond_vec_t w_act;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cal (
    .clk(clk), .rst(rst), .i_d(mcb3_calib_done), .o_q(w_cal_s)
  );
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_err (
    .clk(clk), .rst(rst), .i_d(mcb3_error), .o_q(w_err_s)
  );

  // Fault latch: first fault is kept until cleared; valid wins over a same-cycle clear.
  logic [11:0] r_fault_code;
  logic        r_fault_pending;

  // NOTE: the fault code register is reset too, so a lost latch never shows stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault_code    <= 12'h000;
      r_fault_pending <= 1'b0;
    end else if (fault_valid && (!r_fault_pending || fault_clear)) begin
      r_fault_code    <= fault_code;
      r_fault_pending <= 1'b1;
    end else if (fault_clear) begin
      r_fault_pending <= 1'b0;
    end
  end

`ifdef STATUS_STICKY_MEMERR_EN
  logic r_memerr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_memerr <= 1'b0;
    else if (w_err_s)     r_memerr <= 1'b1;
    else if (fault_clear) r_memerr <= 1'b0;
  end
  assign w_memerr = r_memerr;
`else
  assign w_memerr = w_err_s;
`endif

  always_comb begin
    w_act              = '0;
    w_act[IDX_UNCALIB] = ~w_cal_s;
    w_act[IDX_MEMERR]  = w_memerr;
    w_act[IDX_FAULT]   = r_fault_pending;
  end

  sel_state_e       r_state, w_state_nxt;
  cond_idx_t        r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SHOW;
      r_idx   <= cond_idx_t'(IDX_UNCALIB);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = '0;
    if (w_act == '0) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_IDLE || !w_act[r_idx]) begin
      w_state_nxt = ST_SHOW;
      w_idx_nxt   = lowest_active(w_act);
    end else if (r_cnt == CNT_LAST) begin
      w_idx_nxt   = next_active(w_act, r_idx);
    end else begin
      w_cnt_nxt   = r_cnt + 1'b1;
    end
  end

  logic [11:0] w_code;
  always_comb begin
    w_code = STATUS_DEFAULT;
    if (r_state == ST_SHOW) begin
      case (r_idx)
        cond_idx_t'(IDX_UNCALIB): w_code = STATUS_MEM_UNCALIB;
        cond_idx_t'(IDX_MEMERR):  w_code = STATUS_MEM_ERROR;
        cond_idx_t'(IDX_FAULT):   w_code = r_fault_code;
        default:                  w_code = STATUS_DEFAULT;
      endcase
    end
  end

  logic [11:0] r_state_code;
  logic        r_multi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_code <= STATUS_MEM_UNCALIB;
      r_multi      <= 1'b0;
    end else begin
      r_state_code <= w_code;
      r_multi      <= ($countones(w_act) >= 2);
    end
  end

  assign state_code    = r_state_code;
  assign fault_pending = r_fault_pending;
  assign multi_active  = r_multi;

endmodule

// File: tb/tb_status_code_sel.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_status_code_sel;

  localparam int ROT = 8;
  localparam int SS  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mcb3_calib_done = 1'b0;
  logic        mcb3_error = 1'b0;
  logic        fault_valid = 1'b0;
  logic [11:0] fault_code = 12'h000;
  logic        fault_clear = 1'b0;
  logic [11:0] state_code;
  logic        fault_pending;
  logic        multi_active;

  status_code_sel #(.ROTATE_CYCLES(ROT), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst),
    .mcb3_calib_done(mcb3_calib_done), .mcb3_error(mcb3_error),
    .fault_valid(fault_valid), .fault_code(fault_code), .fault_clear(fault_clear),
    .state_code(state_code), .fault_pending(fault_pending), .multi_active(multi_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pin history, fault latch, what is being shown and for how long.
  bit          m_cal_hist[SS];
  bit          m_err_hist[SS];
  bit          m_pend;
  logic [11:0] m_freg;
  bit          m_sticky;
  bit          m_show;
  int          m_idx;
  int          m_held;
  logic [11:0] m_disp;
  bit          m_multi;

  task automatic model_reset();
    for (int i = 0; i < SS; i++) begin
      m_cal_hist[i] = 1'b0;
      m_err_hist[i] = 1'b0;
    end
    m_pend = 0; m_freg = 12'h000; m_sticky = 0;
    m_show = 1; m_idx = 0; m_held = 0;
    m_disp = 12'h500; m_multi = 0;
  endtask

  function automatic logic [11:0] code_of(input int idx, input logic [11:0] freg);
    case (idx)
      0:       return 12'h500;
      1:       return 12'h501;
      default: return freg;
    endcase
  endfunction

  task automatic model_step();
    bit          act[3];
    int          n_act, lowest, nxt;
    bit          err_now;
    if (rst) begin
      model_reset();
      return;
    end
    err_now = m_err_hist[SS-1];
    act[0] = !m_cal_hist[SS-1];
`ifdef STATUS_STICKY_MEMERR_EN
    act[1] = m_sticky;
`else
    act[1] = err_now;
`endif
    act[2] = m_pend;
    n_act = int'(act[0]) + int'(act[1]) + int'(act[2]);
    lowest = act[0] ? 0 : (act[1] ? 1 : 2);

    m_disp  = m_show ? code_of(m_idx, m_freg) : 12'h100;
    m_multi = (n_act >= 2);

    if (n_act == 0) begin
      m_show = 0; m_held = 0;
    end else if (!m_show || !act[m_idx]) begin
      m_show = 1; m_idx = lowest; m_held = 0;
    end else begin
      m_held++;
      if (m_held == ROT) begin
        m_held = 0;
        nxt = m_idx;
        for (int k = 2; k >= 1; k--) if (act[(m_idx + k) % 3]) nxt = (m_idx + k) % 3;
        m_idx = nxt;
      end
    end

    if (fault_valid && (!m_pend || fault_clear)) begin
      m_freg = fault_code; m_pend = 1;
    end else if (fault_clear) begin
      m_pend = 0;
    end
    if (err_now)          m_sticky = 1;
    else if (fault_clear) m_sticky = 0;

    for (int i = SS - 1; i > 0; i--) begin
      m_cal_hist[i] = m_cal_hist[i-1];
      m_err_hist[i] = m_err_hist[i-1];
    end
    m_cal_hist[0] = mcb3_calib_done;
    m_err_hist[0] = mcb3_error;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state_code",    state_code,    m_disp);
      check("fault_pending", fault_pending, m_pend);
      check("multi_active",  multi_active,  m_multi);
    end
  end

  // One clock: inputs already applied; model advances after this cycle's compare.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    model_reset();
  endtask

  int changes, bad;
  logic [11:0] prev;

  initial begin
    model_reset();
    cmp_en = 1'b1;
    @(posedge clk); #1;
    tick(2);
    check("reset_state_code", state_code, 12'h500);
    check("reset_fault_pending", fault_pending, 1'b0);
    rst = 1'b0;

    // 1: calibration completes
    tick(10);
    check("uncalib_code", state_code, 12'h500);
    mcb3_calib_done = 1'b1;
    tick(6);
    check("default_code", state_code, 12'h100);
    check("idle_multi", multi_active, 1'b0);

    // 2: first fault kept, second ignored
    fault_valid = 1'b1; fault_code = 12'hA3C;
    tick();
    fault_valid = 1'b0;
    tick(3);
    check("fault_code_shown", state_code, 12'hA3C);
    check("fault_pending_set", fault_pending, 1'b1);
    fault_valid = 1'b1; fault_code = 12'h777;
    tick();
    fault_valid = 1'b0;
    tick(4);
    check("first_fault_kept", state_code, 12'hA3C);

    // 3: memory error plus fault -> rotation
    mcb3_error = 1'b1;
    tick(6);
    check("multi_set", multi_active, 1'b1);
    changes = 0; prev = state_code;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (state_code != prev) changes++;
      prev = state_code;
    end
    check("rotation_alternates", (changes >= 4), 1);

    // 4: drop error mid-interval
    tick(3);
    mcb3_error = 1'b0;
    tick(5);
    check("fault_after_err_drop", state_code, 12'hA3C);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state_code != 12'hA3C) bad++;
    end
    check("no_alternation", bad, 0);

    // 5: valid wins over same-cycle clear; clear alone -> default
    fault_valid = 1'b1; fault_clear = 1'b1; fault_code = 12'h0F0;
    tick();
    fault_valid = 1'b0; fault_clear = 1'b0;
    tick(4);
    check("valid_wins_pending", fault_pending, 1'b1);
    check("valid_wins_code", state_code, 12'h0F0);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    tick(5);
    check("clear_default", state_code, 12'h100);

    // 6: reset mid-rotation
    fault_valid = 1'b1; fault_code = 12'hA3C; mcb3_error = 1'b1;
    tick();
    fault_valid = 1'b0;
    tick(13);
    rst = 1'b1;
    #1;
    check("async_rst_code", state_code, 12'h500);
    check("async_rst_pending", fault_pending, 1'b0);
    model_reset();
    tick(2);
    rst = 1'b0;
    mcb3_error = 1'b0;
    tick(8);

`ifdef STATUS_STICKY_MEMERR_EN
    mcb3_error = 1'b1;
    tick();
    mcb3_error = 1'b0;
    tick(12);
    check("sticky_memerr", state_code, 12'h501);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    tick(5);
    check("sticky_cleared", state_code, 12'h100);
`endif

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) mcb3_calib_done = ~mcb3_calib_done;
      if ($urandom_range(31) == 0) mcb3_error = ~mcb3_error;
      fault_valid = ($urandom_range(15) == 0);
      fault_clear = ($urandom_range(23) == 0);
      fault_code  = 12'($urandom);
      if (rst) rst = 1'b0;
      else if ($urandom_range(499) == 0) assert_rst();
      tick();
    end
    fault_valid = 1'b0; fault_clear = 1'b0;
    tick(2);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
